// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// arb_pkg : shared constants, buffer-state encoding and clog2 helper
// Rev 1.0
// ============================================================================
package arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : rotating priority picker (rotate, lowest-index encode, rotate back)
// Rev 1.0
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SELW     = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     start,
    input  logic                mode,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     idx
);

    logic [SELW-1:0]     w_start;
    logic [CHANNELS-1:0] w_rot;
    logic [SELW-1:0]     w_pos;
    logic                w_hit;

    // start + offset never reaches 2*CHANNELS, so one conditional subtract wraps it
    function automatic int wrap_idx(input int k);
        return (k >= CHANNELS) ? (k - CHANNELS) : k;
    endfunction

    always_comb begin
        w_start = mode ? start : '0;
        w_rot   = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            w_rot[j] = req[wrap_idx(int'(w_start) + j)];
        end
    end

    always_comb begin
        w_pos = '0;
        w_hit = 1'b0;
        for (int j = CHANNELS - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_hit = 1'b1;
                w_pos = SELW'(j);
            end
        end
    end

    always_comb begin
        idx   = SELW'(wrap_idx(int'(w_start) + int'(w_pos)));
        grant = '0;
        if (w_hit) begin
            grant[idx] = 1'b1;
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/arb_mux.sv
`default_nettype none
// ============================================================================
// arb_mux : N-channel arbitrating mux with a one-entry valid/ready output buffer
// Rev 1.0
// ============================================================================
module arb_mux
    import arb_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = 1,
    localparam int SELW     = clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    input  logic                      out_ready
);

    localparam logic            C_MODE_RR  = (MODE == MODE_RR);
    localparam logic [SELW-1:0] C_PTR_LAST = SELW'(CHANNELS - 1);

    buf_state_t          r_state;
    buf_state_t          w_state_nxt;
    logic [WIDTH-1:0]    r_data;
    logic [SELW-1:0]     r_chan;
    logic [SELW-1:0]     r_ptr;

    logic [SELW-1:0]     w_start;
    logic [CHANNELS-1:0] w_grant;
    logic [SELW-1:0]     w_idx;
    logic                w_can_load;
    logic                w_xfer;

    assign w_start = (r_ptr == C_PTR_LAST) ? '0 : (r_ptr + SELW'(1));

    rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_pick (
        .req   (in_valid),
        .start (w_start),
        .mode  (C_MODE_RR),
        .grant (w_grant),
        .idx   (w_idx)
    );

    // reset gates in_ready so nothing looks accepted while the block is held in reset
    assign w_can_load = reset && !flush && ((r_state == BUF_EMPTY) || out_ready);
    assign in_ready   = w_can_load ? w_grant : '0;
    assign w_xfer     = |(in_valid & in_ready);

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = BUF_EMPTY;
        end else if (w_xfer) begin
            w_state_nxt = BUF_FULL;
        end else if ((r_state == BUF_FULL) && out_ready) begin
            w_state_nxt = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // pointer only follows taken grants; flush never coincides with a transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_chan <= '0;
            r_ptr  <= C_PTR_LAST;
        end else if (w_xfer) begin
            r_data <= in_data[int'(w_idx)*WIDTH +: WIDTH];
            r_chan <= w_idx;
            r_ptr  <= w_idx;
        end
    end

    assign out_valid = (r_state == BUF_FULL);
    assign out_data  = r_data;
    assign out_chan  = r_chan;

endmodule : arb_mux
`default_nettype wire

// File: tb/tb_arb_mux.sv
`default_nettype none
// ============================================================================
// tb_arb_mux : vector table plus scoreboard bench for arb_mux (RR and fixed)
// Rev 1.0
// ============================================================================
module tb_arb_mux;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk;
    logic         rst_n;
    logic [C-1:0] in_valid;
    logic [C*W-1:0] in_data;
    logic         flush;
    logic         out_ready;

    logic [C-1:0] rdy_rr, rdy_fx;
    logic         ov_rr, ov_fx;
    logic [W-1:0] od_rr, od_fx;
    logic [1:0]   oc_rr, oc_fx;

    arb_mux #(.WIDTH(W), .CHANNELS(C), .MODE(1)) dut_rr (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_rr), .flush(flush), .out_valid(ov_rr), .out_data(od_rr),
        .out_chan(oc_rr), .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(W), .CHANNELS(C), .MODE(0)) dut_fx (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_fx), .flush(flush), .out_valid(ov_fx), .out_data(od_fx),
        .out_chan(oc_fx), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic       rdy;
        logic       fl;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_ch;
        logic       fx;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] d;
    } item_t;

    int    errors = 0;
    int    checks = 0;
    item_t sb[$];
    logic  m_valid;
    int    m_ptr;
    vec_t  vec[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] rr_grant(input logic [3:0] v, input int p);
        for (int j = 1; j <= 4; j++) begin
            int k;
            k = (p + j) % 4;
            if (v[k]) return 4'(1 << k);
        end
        return 4'b0000;
    endfunction

    // Inputs are already applied (just after a rising edge); check at the falling edge
    task automatic tick(input string tag, input bit use_tbl, input vec_t t);
        logic [3:0] exp;
        logic       consumed;
        @(negedge clk);
        exp = ((!m_valid || out_ready) && !flush) ? rr_grant(in_valid, m_ptr) : 4'b0000;
        chk({tag, " sb_in_ready"}, 32'(rdy_rr), 32'(exp));
        chk({tag, " sb_out_valid"}, 32'(ov_rr), 32'(m_valid));
        if (m_valid && sb.size() > 0) begin
            chk({tag, " sb_out_data"}, 32'(od_rr), 32'(sb[0].d));
            chk({tag, " sb_out_chan"}, 32'(oc_rr), 32'(sb[0].ch));
        end
        if (use_tbl) begin
            chk({tag, " tbl_in_ready"}, 32'(rdy_rr), 32'(t.exp_rdy));
            chk({tag, " tbl_out_valid"}, 32'(ov_rr), 32'(t.exp_ov));
            if (t.exp_ov) chk({tag, " tbl_out_chan"}, 32'(oc_rr), 32'(t.exp_ch));
            if (t.fx) begin
                chk({tag, " fx_in_ready"}, 32'(rdy_fx), 32'h1);
                if (ov_fx) begin
                    chk({tag, " fx_out_chan"}, 32'(oc_fx), 32'h0);
                    chk({tag, " fx_out_data"}, 32'(od_fx), 32'hA0);
                end
            end
        end
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
            sb.delete();
        end else begin
            consumed = m_valid && out_ready;
            if (consumed && sb.size() > 0) void'(sb.pop_front());
            if (exp != 4'b0000) begin
                for (int k = 0; k < 4; k++) begin
                    if (exp[k]) begin
                        sb.push_back('{ch: 2'(k), d: 8'(8'hA0 + k)});
                        m_ptr = k;
                    end
                end
                m_valid = 1'b1;
            end else if (consumed) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        vec_t none;
        none = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0};
        // {in_valid, out_ready, flush, in_ready, out_valid, out_chan, check fixed}
        vec[0]  = '{4'hF, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1};
        vec[1]  = '{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b1};
        vec[2]  = '{4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 1'b1};
        vec[3]  = '{4'hF, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 1'b1};
        vec[4]  = '{4'hF, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3, 1'b1};
        vec[5]  = '{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b1};
        vec[6]  = '{4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1, 1'b1};
        vec[7]  = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
        vec[8]  = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
        vec[9]  = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
        vec[10] = '{4'hF, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
        vec[11] = '{4'hF, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 1'b0};
        vec[12] = '{4'h2, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0};
        vec[13] = '{4'h2, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0};
        vec[14] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b0};
        vec[15] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vec[16] = '{4'h5, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0};
        vec[17] = '{4'h1, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0};
        vec[18] = '{4'h9, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2, 1'b0};
        vec[19] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b0};
        vec[20] = '{4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vec[21] = '{4'h4, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0};

        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b0;
        flush     = 1'b0;
        m_valid   = 1'b0;
        m_ptr     = 3;

        @(negedge clk);
        chk("in_reset rr_in_ready", 32'(rdy_rr), 32'h0);
        chk("in_reset fx_in_ready", 32'(rdy_fx), 32'h0);
        chk("in_reset out_valid", 32'(ov_rr), 32'h0);
        in_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d out_valid", i), 32'(ov_rr), 32'h0);
            chk($sformatf("idle%0d out_data", i), 32'(od_rr), 32'h0);
            chk($sformatf("idle%0d out_chan", i), 32'(oc_rr), 32'h0);
            chk($sformatf("idle%0d in_ready", i), 32'(rdy_rr), 32'h0);
        end
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            in_valid  = vec[i].v;
            out_ready = vec[i].rdy;
            flush     = vec[i].fl;
            tick($sformatf("vec%0d", i), 1'b1, vec[i]);
        end

        // Buffer now FULL with channel 2 (ptr=2); assert reset between edges
        in_valid  = 4'hF;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst out_valid", 32'(ov_rr), 32'h0);
        chk("async_rst out_data", 32'(od_rr), 32'h0);
        chk("async_rst out_chan", 32'(oc_rr), 32'h0);
        chk("async_rst in_ready", 32'(rdy_rr), 32'h0);
        m_valid = 1'b0;
        m_ptr   = 3;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick("post_rst0", 1'b1, '{4'hF, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0});
        tick("post_rst1", 1'b1, '{4'hF, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0});
        in_valid = 4'h0;
        tick("drain0", 1'b0, none);
        tick("drain1", 1'b0, none);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_arb_mux
`default_nettype wire
